// File: rtl/gray_packer_pkg.sv
// Shared constants, FIFO entry type and luma helper
// for the gray pixel packer.
package gray_packer_pkg;

  localparam int PIX_W      = 24;
  localparam int WORD_W     = 32;
  localparam int LANES      = 4;
  localparam int LUMA_R     = 77;
  localparam int LUMA_G     = 150;
  localparam int LUMA_B     = 29;
  localparam int LUMA_SHIFT = 8;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  // 16 bits is exact: 255 * (77+150+29) = 65280
  function automatic logic [7:0] luma(
    input logic [PIX_W-1:0] p
  );
    logic [15:0] s;
    s = 16'(LUMA_R) * 16'(p[23:16])
      + 16'(LUMA_G) * 16'(p[15:8])
      + 16'(LUMA_B) * 16'(p[7:0]);
    return 8'(s >> LUMA_SHIFT);
  endfunction

endpackage

// File: rtl/gray_pixel_packer_if.sv
// Pixel-in / packed-word-out bundle of the packer.
// master = packer side, slave = pattern gen + consumer.
interface gray_pixel_packer_if;
  import gray_packer_pkg::*;

  logic              VideoReady;
  logic [PIX_W-1:0]  video;
  logic [WORD_W-1:0] OutData;
  logic              OutSOF;
  logic              OutEOL;
  logic              OutValid;
  logic              OutReady;

  modport master (
    output VideoReady,
    input  video,
    output OutData,
    output OutSOF,
    output OutEOL,
    output OutValid,
    input  OutReady
  );

  modport slave (
    input  VideoReady,
    output video,
    input  OutData,
    input  OutSOF,
    input  OutEOL,
    input  OutValid,
    output OutReady
  );

endinterface

// File: rtl/gray_word_fifo.sv
// First-word-fall-through FIFO, power-of-two depth,
// with occupancy count.
module gray_word_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      do_push && !do_pop: cnt_d = cnt_q + CW'(1);
      do_pop && !do_push: cnt_d = cnt_q - CW'(1);
      default:            cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop)
        rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/gray_pixel_packer.sv
// RGB -> luma, four pixels per 32-bit word, SOF/EOL tags.
// GRAY_PACKER_FRAMECOUNT_EN enables the frame counter.
module gray_pixel_packer
  import gray_packer_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Enable,
  gray_pixel_packer_if.master bus,
  output logic [15:0]         FrameCount
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    lane_q, lane_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [23:0]   pack_q, pack_d;
  logic          run_q;
  logic [7:0]    luma_v;
  logic          accept;
  logic          push;
  logic          pop;
  logic          last_x;
  logic          last_y;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_valid;
  fifo_entry_t   in_e;
  fifo_entry_t   head_e;

  // run_q keeps VideoReady low while reset is applied
  assign bus.VideoReady = Enable & run_q
    & ((lane_q != 2'd3) | (fifo_cnt < CW'(FIFO_DEPTH)));

  assign accept = bus.VideoReady;
  assign luma_v = luma(bus.video);
  assign last_x = (x_q == XW'(H_ACTIVE - 1));
  assign last_y = (y_q == YW'(V_ACTIVE - 1));
  assign push   = accept && (lane_q == 2'd3);
  assign pop    = bus.OutValid && bus.OutReady;

  assign in_e.sof  = (y_q == '0) && (x_q == XW'(3));
  assign in_e.eol  = last_x;
  assign in_e.data = {luma_v, pack_q};

  always_comb begin
    lane_d = lane_q;
    x_d    = x_q;
    y_d    = y_q;
    pack_d = pack_q;
    if (accept) begin
      lane_d = lane_q + 2'd1;
      unique case (1'b1)
        lane_q == 2'd0: pack_d[7:0]   = luma_v;
        lane_q == 2'd1: pack_d[15:8]  = luma_v;
        lane_q == 2'd2: pack_d[23:16] = luma_v;
        default:        pack_d        = pack_q;
      endcase
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      pack_q <= '0;
      run_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      x_q    <= x_d;
      y_q    <= y_d;
      pack_q <= pack_d;
      run_q  <= 1'b1;
    end
  end

  gray_word_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  (in_e),
    .pop_i  (pop),
    .dout_o (head_e),
    .valid_o(fifo_valid),
    .count_o(fifo_cnt)
  );

  assign bus.OutValid = fifo_valid;
  assign bus.OutData  = head_e.data;
  assign bus.OutSOF   = head_e.sof;
  assign bus.OutEOL   = head_e.eol;

`ifdef GRAY_PACKER_FRAMECOUNT_EN
  logic [15:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (push && last_x && last_y)
      fc_d = fc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fc_q <= '0;
    else        fc_q <= fc_d;
  end

  assign FrameCount = fc_q;
`else
  assign FrameCount = 16'd0;
`endif

endmodule
